// File: rtl/lc3_pkg.sv
// Shared LC-3 PSR definitions: PSR field positions, stack sequencer states,
// default vector base / supervisor stack pointer, and a PSR packing helper.
package lc3_pkg;

  localparam int unsigned PSR_PRIV_BIT = 15;
  localparam int unsigned PSR_PRI_MSB  = 10;
  localparam int unsigned PSR_PRI_LSB  = 8;
  localparam int unsigned PSR_N_BIT    = 2;
  localparam int unsigned PSR_Z_BIT    = 1;
  localparam int unsigned PSR_P_BIT    = 0;

  localparam logic [15:0] VEC_BASE_DEF = 16'h0100;
  localparam logic [15:0] SSP_INIT_DEF = 16'h3000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_PSR,
    ST_PUSH_PC,
    ST_RD_VEC,
    ST_POP_PC,
    ST_POP_PSR,
    ST_COMMIT
  } psr_state_e;

  // Build a PSR word; unused bits are written as zero.
  function automatic logic [15:0] psr_pack(input logic       priv,
                                           input logic [2:0] pri,
                                           input logic       n,
                                           input logic       z,
                                           input logic       p);
    logic [15:0] w;
    w                            = '0;
    w[PSR_PRIV_BIT]              = priv;
    w[PSR_PRI_MSB:PSR_PRI_LSB]   = pri;
    w[PSR_N_BIT]                 = n;
    w[PSR_Z_BIT]                 = z;
    w[PSR_P_BIT]                 = p;
    return w;
  endfunction

endpackage

// File: rtl/lc3_psr_reg.sv
// Architectural privilege state: PRIV, PRI and the saved USP/SSP pair.
// Updated only through the commit / load ports driven by lc3_psr_stack.
module lc3_psr_reg
  import lc3_pkg::*;
#(
  parameter logic [15:0] SSP_INIT = SSP_INIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        commit_en,
  input  logic        commit_priv,
  input  logic [2:0]  commit_pri,
  input  logic        usp_ld,
  input  logic [15:0] usp_in,
  input  logic        ssp_ld,
  input  logic [15:0] ssp_in,
  output logic        priv,
  output logic [2:0]  pri,
  output logic [15:0] usp,
  output logic [15:0] ssp
);

  logic        priv_q, priv_d;
  logic [2:0]  pri_q,  pri_d;
  logic [15:0] usp_q,  usp_d;
  logic [15:0] ssp_q,  ssp_d;

  // Next-state selection for each architectural register.
  always_comb begin
    priv_d = priv_q;
    pri_d  = pri_q;
    usp_d  = usp_q;
    ssp_d  = ssp_q;
    if (commit_en) begin
      priv_d = commit_priv;
      pri_d  = commit_pri;
    end
    if (usp_ld) usp_d = usp_in;
    if (ssp_ld) ssp_d = ssp_in;
  end

  // Register update with asynchronous reset to supervisor mode, priority 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      priv_q <= 1'b0;
      pri_q  <= '0;
      usp_q  <= '0;
      ssp_q  <= SSP_INIT;
    end else begin
      priv_q <= priv_d;
      pri_q  <= pri_d;
      usp_q  <= usp_d;
      ssp_q  <= ssp_d;
    end
  end

  assign priv = priv_q;
  assign pri  = pri_q;
  assign usp  = usp_q;
  assign ssp  = ssp_q;

endmodule

// File: rtl/lc3_psr_stack.sv
// LC-3 interrupt entry / RTI sequencer: pushes PSR and PC to the supervisor
// stack, fetches the vector, and on RTI pops PC/PSR and restores NZP, PRIV,
// PRI and R6 (with USP/SSP swap).
// Optional build macro: LC3_RTI_PRIV_CHECK_EN (RTI in user mode raises EXC).
module lc3_psr_stack
  import lc3_pkg::*;
#(
  parameter logic [15:0] SSP_INIT = SSP_INIT_DEF,
  parameter logic [15:0] VEC_BASE = VEC_BASE_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        INT_REQ,
  input  logic [7:0]  INT_VEC,
  input  logic [2:0]  INT_PRI,
  input  logic        RTI_REQ,
  input  logic [15:0] PC_IN,
  input  logic        N_IN,
  input  logic        Z_IN,
  input  logic        P_IN,
  input  logic [15:0] R6_IN,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_RDY,
  output logic        PRIV,
  output logic [2:0]  PRI,
  output logic        CC_LD,
  output logic        N_OUT,
  output logic        Z_OUT,
  output logic        P_OUT,
  output logic        PC_LD,
  output logic [15:0] PC_OUT,
  output logic        R6_LD,
  output logic [15:0] R6_OUT,
  output logic        BUSY,
  output logic        EXC
);

  psr_state_e  state_q, state_d;
  logic        is_rti_q, is_rti_d;
  logic [7:0]  vec_q, vec_d;
  logic [2:0]  ipri_q, ipri_d;
  logic [15:0] sp_q, sp_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ppriv_q, ppriv_d;
  logic [2:0]  ppri_q, ppri_d;
  logic [2:0]  pnzp_q, pnzp_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        cc_ld_q, cc_ld_d;
  logic        pc_ld_q, pc_ld_d;
  logic        r6_ld_q, r6_ld_d;
  logic        exc_q, exc_d;
  logic [2:0]  nzp_out_q, nzp_out_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [15:0] r6_out_q, r6_out_d;

  logic        priv, commit_en, commit_priv, usp_ld, ssp_ld;
  logic [2:0]  pri, commit_pri;
  logic [15:0] usp, ssp, usp_in, ssp_in;
  logic        mem_done, rti_blocked;
  logic [15:0] int_sp, sp_ret;

`ifdef LC3_RTI_PRIV_CHECK_EN
  assign rti_blocked = priv;
`else
  assign rti_blocked = 1'b0;
`endif

  assign mem_done = mem_req_q & MEM_RDY;
  assign int_sp   = priv ? ssp : R6_IN;
  assign sp_ret   = sp_q + 16'd2;

  lc3_psr_reg #(
    .SSP_INIT (SSP_INIT)
  ) u_psr_reg (
    .clk         (CLK),
    .rst_n       (RST_N),
    .commit_en   (commit_en),
    .commit_priv (commit_priv),
    .commit_pri  (commit_pri),
    .usp_ld      (usp_ld),
    .usp_in      (usp_in),
    .ssp_ld      (ssp_ld),
    .ssp_in      (ssp_in),
    .priv        (priv),
    .pri         (pri),
    .usp         (usp),
    .ssp         (ssp)
  );

  // Sequencer next state, memory request, and commit outputs.
  always_comb begin
    state_d     = state_q;
    is_rti_d    = is_rti_q;
    vec_d       = vec_q;
    ipri_d      = ipri_q;
    sp_d        = sp_q;
    rdata_d     = rdata_q;
    ppriv_d     = ppriv_q;
    ppri_d      = ppri_q;
    pnzp_d      = pnzp_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cc_ld_d     = 1'b0;
    pc_ld_d     = 1'b0;
    r6_ld_d     = 1'b0;
    exc_d       = 1'b0;
    nzp_out_d   = nzp_out_q;
    pc_out_d    = pc_out_q;
    r6_out_d    = r6_out_q;
    commit_en   = 1'b0;
    commit_priv = 1'b0;
    commit_pri  = '0;
    usp_ld      = 1'b0;
    usp_in      = R6_IN;
    ssp_ld      = 1'b0;
    ssp_in      = sp_ret;

    unique case (state_q)
      ST_IDLE: begin
        if (RTI_REQ) begin
          if (rti_blocked) begin
            exc_d = 1'b1;
          end else begin
            is_rti_d   = 1'b1;
            sp_d       = R6_IN;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = R6_IN;
            state_d    = ST_POP_PC;
          end
        end else if (INT_REQ && (INT_PRI > pri)) begin
          is_rti_d    = 1'b0;
          vec_d       = INT_VEC;
          ipri_d      = INT_PRI;
          sp_d        = int_sp;
          usp_ld      = priv;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = int_sp - 16'd1;
          mem_wdata_d = psr_pack(priv, pri, N_IN, Z_IN, P_IN);
          state_d     = ST_PUSH_PSR;
        end
      end
      ST_PUSH_PSR: begin
        if (mem_done) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = sp_q - 16'd2;
          mem_wdata_d = PC_IN;
          state_d     = ST_PUSH_PC;
        end
      end
      ST_PUSH_PC: begin
        if (mem_done) begin
          mem_we_d   = 1'b0;
          mem_addr_d = VEC_BASE + {8'h00, vec_q};
          state_d    = ST_RD_VEC;
        end
      end
      ST_RD_VEC: begin
        if (mem_done) begin
          rdata_d   = MEM_RDATA;
          mem_req_d = 1'b0;
          state_d   = ST_COMMIT;
        end
      end
      ST_POP_PC: begin
        if (mem_done) begin
          rdata_d    = MEM_RDATA;
          mem_addr_d = sp_q + 16'd1;
          state_d    = ST_POP_PSR;
        end
      end
      ST_POP_PSR: begin
        if (mem_done) begin
          ppriv_d   = MEM_RDATA[PSR_PRIV_BIT];
          ppri_d    = MEM_RDATA[PSR_PRI_MSB:PSR_PRI_LSB];
          pnzp_d    = {MEM_RDATA[PSR_N_BIT], MEM_RDATA[PSR_Z_BIT], MEM_RDATA[PSR_P_BIT]};
          mem_req_d = 1'b0;
          state_d   = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // Strobes and the PRIV/PRI update land on the same edge that returns
        // to IDLE, so a reset before this edge leaves no partial commit.
        state_d   = ST_IDLE;
        pc_out_d  = rdata_q;
        pc_ld_d   = 1'b1;
        r6_ld_d   = 1'b1;
        commit_en = 1'b1;
        if (is_rti_q) begin
          cc_ld_d     = 1'b1;
          nzp_out_d   = pnzp_q;
          commit_priv = ppriv_q;
          commit_pri  = ppri_q;
          if (ppriv_q) begin
            ssp_ld   = 1'b1;
            r6_out_d = usp;
          end else begin
            r6_out_d = sp_ret;
          end
        end else begin
          commit_priv = 1'b0;
          commit_pri  = ipri_q;
          r6_out_d    = sp_q - 16'd2;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      is_rti_q    <= 1'b0;
      vec_q       <= '0;
      ipri_q      <= '0;
      sp_q        <= '0;
      rdata_q     <= '0;
      ppriv_q     <= 1'b0;
      ppri_q      <= '0;
      pnzp_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cc_ld_q     <= 1'b0;
      pc_ld_q     <= 1'b0;
      r6_ld_q     <= 1'b0;
      exc_q       <= 1'b0;
      nzp_out_q   <= '0;
      pc_out_q    <= '0;
      r6_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      is_rti_q    <= is_rti_d;
      vec_q       <= vec_d;
      ipri_q      <= ipri_d;
      sp_q        <= sp_d;
      rdata_q     <= rdata_d;
      ppriv_q     <= ppriv_d;
      ppri_q      <= ppri_d;
      pnzp_q      <= pnzp_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cc_ld_q     <= cc_ld_d;
      pc_ld_q     <= pc_ld_d;
      r6_ld_q     <= r6_ld_d;
      exc_q       <= exc_d;
      nzp_out_q   <= nzp_out_d;
      pc_out_q    <= pc_out_d;
      r6_out_q    <= r6_out_d;
    end
  end

  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign PRIV      = priv;
  assign PRI       = pri;
  assign CC_LD     = cc_ld_q;
  assign N_OUT     = nzp_out_q[2];
  assign Z_OUT     = nzp_out_q[1];
  assign P_OUT     = nzp_out_q[0];
  assign PC_LD     = pc_ld_q;
  assign PC_OUT    = pc_out_q;
  assign R6_LD     = r6_ld_q;
  assign R6_OUT    = r6_out_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign EXC       = exc_q;

endmodule

// File: tb/tb_lc3_psr_stack.sv
// Directed bench for lc3_psr_stack with a wait-state-capable memory model.
module tb_lc3_psr_stack;

  logic        CLK, RST_N;
  logic        INT_REQ, RTI_REQ;
  logic [7:0]  INT_VEC;
  logic [2:0]  INT_PRI;
  logic [15:0] PC_IN, R6_IN;
  logic        N_IN, Z_IN, P_IN;
  logic        MEM_REQ, MEM_WE, MEM_RDY;
  logic [15:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
  logic        PRIV, CC_LD, N_OUT, Z_OUT, P_OUT, PC_LD, R6_LD, BUSY, EXC;
  logic [2:0]  PRI;
  logic [15:0] PC_OUT, R6_OUT;

  int n_cmp = 0;
  int n_fail = 0;

  lc3_psr_stack #(
    .SSP_INIT (16'h3000),
    .VEC_BASE (16'h0100)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .INT_REQ   (INT_REQ),
    .INT_VEC   (INT_VEC),
    .INT_PRI   (INT_PRI),
    .RTI_REQ   (RTI_REQ),
    .PC_IN     (PC_IN),
    .N_IN      (N_IN),
    .Z_IN      (Z_IN),
    .P_IN      (P_IN),
    .R6_IN     (R6_IN),
    .MEM_REQ   (MEM_REQ),
    .MEM_WE    (MEM_WE),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_WDATA (MEM_WDATA),
    .MEM_RDATA (MEM_RDATA),
    .MEM_RDY   (MEM_RDY),
    .PRIV      (PRIV),
    .PRI       (PRI),
    .CC_LD     (CC_LD),
    .N_OUT     (N_OUT),
    .Z_OUT     (Z_OUT),
    .P_OUT     (P_OUT),
    .PC_LD     (PC_LD),
    .PC_OUT    (PC_OUT),
    .R6_LD     (R6_LD),
    .R6_OUT    (R6_OUT),
    .BUSY      (BUSY),
    .EXC       (EXC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory model: answers MEM_RDY after wait_cyc extra cycles, logs writes,
  // and counts any change of address/control/data while a request waits.
  logic [15:0] mem [0:65535];
  logic [15:0] wr_addr [$];
  logic [15:0] wr_data [$];
  int          wait_cyc = 0;
  int          wcnt = 0;
  int          unstable = 0;
  logic [15:0] h_addr, h_wdata;
  logic        h_we;

  always @(negedge CLK) begin
    if (!MEM_REQ) begin
      wcnt    = 0;
      MEM_RDY = 1'b0;
    end else begin
      if (MEM_RDY || wcnt == 0) begin
        wcnt    = 0;
        h_addr  = MEM_ADDR;
        h_we    = MEM_WE;
        h_wdata = MEM_WDATA;
      end else if (MEM_ADDR !== h_addr || MEM_WE !== h_we ||
                   (h_we && MEM_WDATA !== h_wdata)) begin
        unstable++;
      end
      if (wcnt >= wait_cyc) begin
        MEM_RDY = 1'b1;
        if (MEM_WE) begin
          mem[MEM_ADDR] = MEM_WDATA;
          wr_addr.push_back(MEM_ADDR);
          wr_data.push_back(MEM_WDATA);
        end else begin
          MEM_RDATA = mem[MEM_ADDR];
        end
      end else begin
        MEM_RDY = 1'b0;
        wcnt++;
      end
    end
  end

  // Strobe counters, sampled mid-cycle.
  int pc_ld_cnt = 0;
  int r6_ld_cnt = 0;
  int exc_cnt = 0;
  always @(negedge CLK) begin
    if (PC_LD === 1'b1) pc_ld_cnt++;
    if (R6_LD === 1'b1) r6_ld_cnt++;
    if (EXC === 1'b1)   exc_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise an interrupt; lat = cycles from acceptance edge to PC_LD (-1 on timeout).
  task automatic do_int(input logic [7:0] vec, input logic [2:0] ipri, output int lat);
    @(negedge CLK);
    INT_VEC = vec;
    INT_PRI = ipri;
    INT_REQ = 1'b1;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLK);
      INT_REQ = 1'b0;
      if (PC_LD === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic do_rti(output int lat);
    @(negedge CLK);
    RTI_REQ = 1'b1;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLK);
      RTI_REQ = 1'b0;
      if (PC_LD === 1'b1) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  int lat;
  int seen;
  int pc_ld_snap, r6_ld_snap;
  logic found;

  initial begin
    RST_N   = 1'b0;
    INT_REQ = 1'b0;
    RTI_REQ = 1'b0;
    INT_VEC = '0;
    INT_PRI = '0;
    PC_IN   = '0;
    R6_IN   = '0;
    N_IN    = 1'b0;
    Z_IN    = 1'b0;
    P_IN    = 1'b0;
    MEM_RDY = 1'b0;
    MEM_RDATA = '0;
    #3;
    // Reset state
    chk("rst_mem_req", {15'd0, MEM_REQ}, 16'd0);
    chk("rst_busy",    {15'd0, BUSY},    16'd0);
    chk("rst_priv",    {15'd0, PRIV},    16'd0);
    chk("rst_pri",     {13'd0, PRI},     16'd0);
    chk("rst_pc_out",  PC_OUT,           16'h0000);
    chk("rst_r6_out",  R6_OUT,           16'h0000);
    chk("rst_strobes", {12'd0, PC_LD, R6_LD, CC_LD, EXC}, 16'd0);
    chk("rst_nzp",     {13'd0, N_OUT, Z_OUT, P_OUT}, 16'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // RTI from reset into user mode: frame PC=4000, PSR=8001 at 2FFE.
    mem[16'h2FFE] = 16'h4000;
    mem[16'h2FFF] = 16'h8001;
    R6_IN = 16'h2FFE;
    do_rti(lat);
    chk("rti0_lat",    16'(lat),  16'd3);
    chk("rti0_pc",     PC_OUT,    16'h4000);
    chk("rti0_nzp",    {13'd0, N_OUT, Z_OUT, P_OUT}, 16'h0001);
    chk("rti0_cc_ld",  {15'd0, CC_LD}, 16'd1);
    chk("rti0_r6_ld",  {15'd0, R6_LD}, 16'd1);
    chk("rti0_priv",   {15'd0, PRIV},  16'd1);
    chk("rti0_pri",    {13'd0, PRI},   16'd0);
    chk("rti0_r6_out", R6_OUT,    16'h0000);
    @(negedge CLK);
    chk("rti0_pc_ld_width", {15'd0, PC_LD}, 16'd0);

    // Interrupt from user mode.
    R6_IN = 16'hFE00;
    PC_IN = 16'h3050;
    {N_IN, Z_IN, P_IN} = 3'b010;
    mem[16'h0180] = 16'h1000;
    wr_addr.delete();
    wr_data.delete();
    do_int(8'h80, 3'd4, lat);
    chk("int_lat",     16'(lat), 16'd4);
    chk("int_nwr",     16'(wr_addr.size()), 16'd2);
    if (wr_addr.size() == 2) begin
      chk("int_wr0_addr", wr_addr[0], 16'h2FFF);
      chk("int_wr0_data", wr_data[0], 16'h8002);
      chk("int_wr1_addr", wr_addr[1], 16'h2FFE);
      chk("int_wr1_data", wr_data[1], 16'h3050);
    end
    chk("int_pc",      PC_OUT, 16'h1000);
    chk("int_r6_out",  R6_OUT, 16'h2FFE);
    chk("int_r6_ld",   {15'd0, R6_LD}, 16'd1);
    chk("int_cc_ld",   {15'd0, CC_LD}, 16'd0);
    chk("int_priv",    {15'd0, PRIV},  16'd0);
    chk("int_pri",     {13'd0, PRI},   16'd4);

    // RTI back to user mode.
    R6_IN = 16'h2FFE;
    do_rti(lat);
    chk("rti1_lat",    16'(lat), 16'd3);
    chk("rti1_pc",     PC_OUT,   16'h3050);
    chk("rti1_nzp",    {13'd0, N_OUT, Z_OUT, P_OUT}, 16'h0002);
    chk("rti1_cc_ld",  {15'd0, CC_LD}, 16'd1);
    chk("rti1_priv",   {15'd0, PRIV},  16'd1);
    chk("rti1_pri",    {13'd0, PRI},   16'd0);
    chk("rti1_r6_out", R6_OUT,   16'hFE00);
    @(negedge CLK);
    chk("rti1_cc_ld_width", {15'd0, CC_LD}, 16'd0);

    // RTI issued in user mode.
`ifdef LC3_RTI_PRIV_CHECK_EN
    RTI_REQ = 1'b1;
    @(negedge CLK);
    RTI_REQ = 1'b0;
    chk("urti_exc",     {15'd0, EXC},     16'd1);
    chk("urti_mem_req", {15'd0, MEM_REQ}, 16'd0);
    chk("urti_busy",    {15'd0, BUSY},    16'd0);
    @(negedge CLK);
    chk("urti_exc_width", {15'd0, EXC},   16'd0);
    chk("urti_mem_req2",  {15'd0, MEM_REQ}, 16'd0);
    chk("urti_exc_cnt",   16'(exc_cnt),   16'd1);
`else
    do_rti(lat);
    chk("urti_lat",     16'(lat), 16'd3);
    chk("urti_pc",      PC_OUT,   16'h3050);
    chk("urti_r6_out",  R6_OUT,   16'hFE00);
    chk("urti_exc_cnt", 16'(exc_cnt), 16'd0);
`endif
    chk("urti_priv", {15'd0, PRIV}, 16'd1);
    chk("urti_pri",  {13'd0, PRI},  16'd0);

    // Wait states: each access stalls wait_cyc cycles, stretching all three.
    wait_cyc = 3;
    unstable = 0;
    R6_IN = 16'hFE00;
    PC_IN = 16'h1234;
    {N_IN, Z_IN, P_IN} = 3'b100;
    wr_addr.delete();
    wr_data.delete();
    do_int(8'h80, 3'd5, lat);
    chk("ws_lat",      16'(lat), 16'd13);
    chk("ws_unstable", 16'(unstable), 16'd0);
    chk("ws_nwr",      16'(wr_addr.size()), 16'd2);
    if (wr_addr.size() == 2) begin
      chk("ws_wr0_addr", wr_addr[0], 16'h2FFF);
      chk("ws_wr0_data", wr_data[0], 16'h8004);
      chk("ws_wr1_addr", wr_addr[1], 16'h2FFE);
      chk("ws_wr1_data", wr_data[1], 16'h1234);
    end
    chk("ws_pc",   PC_OUT, 16'h1000);
    chk("ws_priv", {15'd0, PRIV}, 16'd0);
    chk("ws_pri",  {13'd0, PRI},  16'd5);

    // Priority masking: lower and equal priority are both ignored.
    wait_cyc = 0;
    seen = 0;
    @(negedge CLK);
    INT_PRI = 3'd3;
    INT_REQ = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (MEM_REQ !== 1'b0 || BUSY !== 1'b0) seen++;
    end
    chk("mask_lower", 16'(seen), 16'd0);
    seen = 0;
    INT_PRI = 3'd5;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (MEM_REQ !== 1'b0 || BUSY !== 1'b0) seen++;
    end
    INT_REQ = 1'b0;
    chk("mask_equal", 16'(seen), 16'd0);

    // Reset during PUSH_PC; SP=0001 also exercises address wrap.
    wait_cyc = 2;
    R6_IN = 16'h0001;
    PC_IN = 16'hBEEF;
    {N_IN, Z_IN, P_IN} = 3'b001;
    wr_addr.delete();
    wr_data.delete();
    pc_ld_snap = pc_ld_cnt;
    r6_ld_snap = r6_ld_cnt;
    found = 1'b0;
    @(negedge CLK);
    INT_PRI = 3'd7;
    INT_REQ = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      INT_REQ = 1'b0;
      if (MEM_REQ === 1'b1 && MEM_WE === 1'b1 && MEM_ADDR === 16'hFFFF) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstm_found_push_pc", {15'd0, found}, 16'd1);
    chk("rstm_nwr",   16'(wr_addr.size()), 16'd1);
    if (wr_addr.size() == 1) begin
      chk("rstm_wr0_addr", wr_addr[0], 16'h0000);
      chk("rstm_wr0_data", wr_data[0], 16'h0501);
    end
    chk("rstm_pc_wdata", MEM_WDATA, 16'hBEEF);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rstm_mem_req",   {15'd0, MEM_REQ}, 16'd0);
    chk("rstm_mem_addr",  MEM_ADDR,  16'h0000);
    chk("rstm_mem_wdata", MEM_WDATA, 16'h0000);
    chk("rstm_busy",      {15'd0, BUSY}, 16'd0);
    chk("rstm_priv",      {15'd0, PRIV}, 16'd0);
    chk("rstm_pri",       {13'd0, PRI},  16'd0);
    chk("rstm_pc_out",    PC_OUT, 16'h0000);
    chk("rstm_r6_out",    R6_OUT, 16'h0000);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 8; k++) @(negedge CLK);
    chk("rstm_no_pc_ld", 16'(pc_ld_cnt - pc_ld_snap), 16'd0);
    chk("rstm_no_r6_ld", 16'(r6_ld_cnt - r6_ld_snap), 16'd0);
    chk("rstm_idle",     {15'd0, BUSY}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
